dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data RAM between the RV32I core datapath (load/store port: aluRes address, writeData, readData) and the boot/debug loader.
- Stalls the single-cycle core (freezes PC and register write) while the core loses arbitration or waits one cycle for synchronous read data.
- Core has fixed priority; a starvation counter guarantees the loader a slot.
- Sits between the datapath/control unit and the RAM macro.

Parameters:
- ADDR_W, 16, RAM byte-address width (matches 16-bit ram/rom addresses).
- DATA_W, 32, data word width.
- STARVE_LIM, 8, consecutive denied loader-request cycles after which the loader wins one slot over the core.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- core_req  in  1  core performs a load or store this instruction
- core_we  in  1  1 = store, 0 = load
- core_addr  in  ADDR_W  core address (aluRes[15:0])
- core_wdata  in  DATA_W  store data
- core_rdata  out  DATA_W  load data to the datapath readData path
- core_stall  out  1  hold PC/regWrite this cycle
- ldr_req  in  1  loader access request
- ldr_we  in  1  loader write enable
- ldr_addr  in  ADDR_W  loader address
- ldr_wdata  in  DATA_W  loader write data
- ldr_gnt  out  1  loader access issued this cycle
- ldr_rvalid  out  1  loader read data valid
- ldr_rdata  out  DATA_W  loader read data
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid 1 cycle after a read strobe
- owner  out  2  00 none, 01 core, 10 loader (issuing master, this cycle)

Behaviour:
- Clock clk; reset rst is asynchronous, active-high.
- Reset values: state IDLE, starve_cnt 0, ldr_rvalid 0, ldr_rdata 0. Combinational outputs resolve to mem_en 0, ldr_gnt 0, owner 00, core_stall = core_req.
- States:
  - IDLE: arbitrate and issue at most one access.
  - CORE_RD: core read data returning; no new access issued; unconditional transition to IDLE.
- Arbitration (IDLE only, combinational):
  - loader_wins = ldr_req & (~core_req | starve_cnt == STARVE_LIM).
  - core_wins = core_req & ~loader_wins.
- Mem mux: mem_* driven from the winner; mem_en = core_wins | loader_wins. No winner: mem_en 0, mem_we 0, addr/wdata don't-care.
- Core write won: RAM written this cycle; core_stall 0; state stays IDLE.
- Core read won: read issued; core_stall 1; next state CORE_RD.
- In CORE_RD: core_rdata = mem_rdata; core_stall 0. core_rdata is valid only in this state; otherwise don't-care, drive 0.
- core_stall = core_req & ~(IDLE & core_wins & core_we) & ~CORE_RD.
- Loader:
  - ldr_gnt = loader_wins (IDLE only). The loader holds req/addr/data stable until ldr_gnt.
  - Read granted in cycle N gives ldr_rvalid = 1 and ldr_rdata = mem_rdata registered in cycle N+1 (so data is visible in N+2 from the register). Specify exactly: ldr_rvalid asserted in N+1, ldr_rdata captured from mem_rdata at the end of N+1 and held until the next loader read returns; rvalid pulses for 1 cycle.
  - Back-to-back loader grants are allowed; rvalid is pipelined.
- starve_cnt:
  - Increments (saturating at STARVE_LIM) each cycle ldr_req = 1 and ldr_gnt = 0, including CORE_RD cycles.
  - Clears on ldr_gnt or when ldr_req = 0.
- Simultaneous requests with starve_cnt < LIM: core wins; starve_cnt increments.
- Simultaneous requests with starve_cnt == LIM: loader wins; core stalls one extra cycle.
- rst mid-access: in-flight read is dropped (no rvalid, state IDLE). The core re-presents the access after reset as the PC restarts.
- Address and data pass through unmodified; no alignment checking (byte enables are out of scope).

Decomposition:
- Shared package dmem_pkg: state enum (IDLE, CORE_RD), owner encoding (OWN_NONE, OWN_CORE, OWN_LDR), default widths ADDR_W/DATA_W.
- Single module; no sub-module warranted. The starvation counter is an inline saturating counter.

Test Plan:
1. Core store addr 0x0010 data 0xDEADBEEF, loader idle -> same cycle mem_en = 1, mem_we = 1, mem_addr 0x0010, core_stall = 0, owner 01.
2. Core load 0x0010 after test 1 -> cycle N core_stall = 1, mem_we = 0; cycle N+1 CORE_RD, core_rdata = 0xDEADBEEF, core_stall = 0.
3. Loader reads 0x0020, 0x0024, 0x0028 back-to-back, core idle -> ldr_gnt 3 consecutive cycles; ldr_rvalid pulses 3 consecutive cycles one cycle later, with correct data in order.
4. core_req held high (stores) and ldr_req high from cycle 0 -> core wins cycles 0-7, loader granted at cycle 8 (starve_cnt = 8) with core_stall = 1 that cycle, starve_cnt cleared at cycle 9.
5. Core load and loader request in the same cycle, starve_cnt 0 -> core wins; in CORE_RD no grant; loader granted in the following IDLE cycle.
6. Assert rst during CORE_RD and during a pending loader read -> immediately state IDLE, ldr_rvalid 0, mem_en 0, starve_cnt 0; after release normal arbitration resumes.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants for the data-memory arbiter
package dmem_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 32;

  // Arbiter states
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_CORE_RD = 1'b1;

  // Issuing-master encoding reported on owner
  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CORE = 2'b01;
  localparam logic [1:0] OWN_LDR  = 2'b10;

endpackage

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - core/loader arbiter for the single-port data RAM
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_LIM = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

  localparam int CNT_W = $clog2(STARVE_LIM + 1);

  logic [0:0]       state;
  logic [CNT_W-1:0] starve_cnt;
  logic             is_idle;
  logic             is_core_rd;
  logic             starved;
  logic             loader_wins;
  logic             core_wins;

  // Gating with rst keeps the RAM quiet while reset is held.
  assign is_idle     = (state == ST_IDLE) & ~rst;
  assign is_core_rd  = (state == ST_CORE_RD);
  assign starved     = (starve_cnt == CNT_W'(STARVE_LIM));
  assign loader_wins = is_idle & ldr_req & (~core_req | starved);
  assign core_wins   = is_idle & core_req & ~loader_wins;

  assign mem_en    = core_wins | loader_wins;
  assign mem_we    = (core_wins & core_we) | (loader_wins & ldr_we);
  assign mem_addr  = loader_wins ? ldr_addr : core_addr;
  assign mem_wdata = loader_wins ? ldr_wdata : core_wdata;
  assign ldr_gnt   = loader_wins;
  assign owner     = core_wins ? OWN_CORE : (loader_wins ? OWN_LDR : OWN_NONE);

  // A won store retires in one cycle; a load retires in the CORE_RD cycle.
  assign core_stall = core_req & ~(core_wins & core_we) & ~is_core_rd;
  assign core_rdata = is_core_rd ? mem_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      starve_cnt <= '0;
      ldr_rvalid <= 1'b0;
      ldr_rdata  <= '0;
    end else begin
      state <= (core_wins & ~core_we) ? ST_CORE_RD : ST_IDLE;

      if (ldr_req & ~loader_wins) begin
        if (!starved) starve_cnt <= starve_cnt + CNT_W'(1);
      end else begin
        starve_cnt <= '0;
      end

      // rvalid marks the cycle the RAM presents the loader's word; the
      // register below captures it at the end of that cycle.
      ldr_rvalid <= loader_wins & ~ldr_we;
      if (ldr_rvalid) ldr_rdata <= mem_rdata;
    end
  end

endmodule
